// File: rtl/fc_neuron_scheduler.sv
// fc_neuron_scheduler: runs one shared PE across OUT_SIZE neuron rows, storing saturating-ReLU outputs.
// Define FC_SCHED_TIMEOUT_EN to bound each PE wait to TIMEOUT cycles and flag overruns on err.
module fc_neuron_scheduler #(
  parameter int IN_SIZE = 64,
  parameter int OUT_SIZE = 10,
  parameter int W = 8,
  parameter int ACC_WIDTH = W + 7,
  parameter int TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [W*OUT_SIZE*IN_SIZE-1:0]   weights_flat,
  input  logic [W*OUT_SIZE-1:0]           biases_flat,
  output logic                            pe_start,
  output logic                            pe_clear,
  output logic [W*IN_SIZE-1:0]            pe_weight_row,
  output logic [W-1:0]                    pe_bias,
  input  logic signed [ACC_WIDTH-1:0]     pe_result,
  input  logic                            pe_done,
  output logic [W*OUT_SIZE-1:0]           out_vector_flat,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(OUT_SIZE)-1:0]     neuron_idx,
  output logic                            err
);
  localparam int IW = $clog2(OUT_SIZE);
  localparam logic signed [ACC_WIDTH-1:0] MAX_POS = ACC_WIDTH'((1 << (W - 1)) - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, FIN} state_t;
  state_t state, next;
  logic signed [ACC_WIDTH-1:0] result;
  logic [W-1:0] relu;
  logic timeout;
  if (OUT_SIZE < 2 || TIMEOUT < 1) begin : g_cfg_check
    $error("fc_neuron_scheduler: OUT_SIZE must be >= 2 and TIMEOUT >= 1");
  end
  assign pe_weight_row = weights_flat[neuron_idx*IN_SIZE*W +: IN_SIZE*W];
  assign pe_bias = biases_flat[neuron_idx*W +: W];
  assign relu = (result[ACC_WIDTH-1] || result == '0) ? '0 :
                (result > MAX_POS) ? MAX_POS[W-1:0] : result[W-1:0];
`ifdef FC_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  // pe_done wins over a timeout landing on the same cycle
  assign timeout = (state == WAIT) && !pe_done && (wait_cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wait_cnt <= '0;
      err <= 1'b0;
    end else begin
      wait_cnt <= (state == ISSUE) ? '0 : (state == WAIT) ? wait_cnt + 1'b1 : wait_cnt;
      err <= (state == IDLE && start) ? 1'b0 : (err || timeout);
    end
`else
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? ISSUE : IDLE;
      ISSUE:   next = WAIT;
      WAIT:    next = (pe_done || timeout) ? STORE : WAIT;
      STORE:   next = (neuron_idx == IW'(OUT_SIZE - 1)) ? FIN : ISSUE;
      FIN:     next = IDLE;
      default: next = IDLE;
    endcase
  end
  // control strobes are registered from the next state so they align with the state they mark
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pe_start <= 1'b0;
      pe_clear <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      neuron_idx <= '0;
      out_vector_flat <= '0;
      result <= '0;
    end else begin
      pe_start <= (next == ISSUE);
      pe_clear <= (next == STORE);
      done <= (next == FIN);
      busy <= (next != IDLE);
      if (state == IDLE && start) begin
        neuron_idx <= '0;
        out_vector_flat <= '0;
      end
      if (state == WAIT && (pe_done || timeout)) result <= pe_done ? pe_result : '0;
      if (state == STORE) begin
        out_vector_flat[neuron_idx*W +: W] <= relu;
        if (next == ISSUE) neuron_idx <= neuron_idx + 1'b1;
      end
    end
endmodule
